// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
// Holds the FSM state encoding, default sizing and the multiplier-window codes.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int WIDTH_DEFAULT = 16;
  localparam int ITER          = WIDTH_DEFAULT / 2;

  // Window {b[2i+1], b[2i], b[2i-1]} codes and the multiple each one selects
  localparam logic [2:0] BD_ZERO_LO = 3'b000;  //  0
  localparam logic [2:0] BD_POS1_LO = 3'b001;  // +A
  localparam logic [2:0] BD_POS1_HI = 3'b010;  // +A
  localparam logic [2:0] BD_POS2    = 3'b011;  // +2A
  localparam logic [2:0] BD_NEG2    = 3'b100;  // -2A
  localparam logic [2:0] BD_NEG1_LO = 3'b101;  // -A
  localparam logic [2:0] BD_NEG1_HI = 3'b110;  // -A
  localparam logic [2:0] BD_ZERO_HI = 3'b111;  //  0

endpackage

// File: rtl/booth_digit_enc.sv
// Combinational radix-4 Booth recoder: maps one 3-bit multiplier window to
// the negate / select-A / select-2A control flags.
module booth_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0] i_win,
  output logic       o_neg,
  output logic       o_one,
  output logic       o_two
);

  // Decode the window into flags; zero digits leave all flags clear
  always_comb begin
    o_neg = 1'b0;
    o_one = 1'b0;
    o_two = 1'b0;
    case (i_win)
      BD_ZERO_LO, BD_ZERO_HI: begin
        o_neg = 1'b0;
        o_one = 1'b0;
        o_two = 1'b0;
      end
      BD_POS1_LO, BD_POS1_HI: begin
        o_neg = 1'b0;
        o_one = 1'b1;
        o_two = 1'b0;
      end
      BD_POS2: begin
        o_neg = 1'b0;
        o_one = 1'b0;
        o_two = 1'b1;
      end
      BD_NEG2: begin
        o_neg = 1'b1;
        o_one = 1'b0;
        o_two = 1'b1;
      end
      BD_NEG1_LO, BD_NEG1_HI: begin
        o_neg = 1'b1;
        o_one = 1'b1;
        o_two = 1'b0;
      end
      default: begin
        o_neg = 1'b0;
        o_one = 1'b0;
        o_two = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier retiring one radix-4 Booth digit per cycle.
// IDLE -> RUN (WIDTH/2 cycles) -> DONE (one-cycle result pulse), back-to-back capable.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int N_ITER = WIDTH / 2;
  localparam int PW     = 2 * WIDTH;
  localparam int CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_ITER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;

  logic [WIDTH:0]  w_b_ext;
  logic [2:0]      w_win;
  logic            w_neg;
  logic            w_one;
  logic            w_two;
  logic [PW-1:0]   w_a_ext;
  logic [PW-1:0]   w_mult;
  logic [PW-1:0]   w_mult_x;
  logic [PW-1:0]   w_pp;
  logic [PW-1:0]   w_cin;
  logic [PW-1:0]   w_acc_next;

  // The appended zero supplies b[-1] for the first digit
  assign w_b_ext = {r_b, 1'b0};
  assign w_win   = w_b_ext[{r_cnt, 1'b0} +: 3];
  assign w_a_ext = {{WIDTH{r_a[WIDTH-1]}}, r_a};

  booth_digit_enc u_enc (
    .i_win (w_win),
    .o_neg (w_neg),
    .o_one (w_one),
    .o_two (w_two)
  );

  // Select the multiple, complement for negative digits, shift into place, accumulate
  always_comb begin
    w_mult = {PW{1'b0}};
    if (w_two) begin
      w_mult = {w_a_ext[PW-2:0], 1'b0};
    end else if (w_one) begin
      w_mult = w_a_ext;
    end else begin
      w_mult = {PW{1'b0}};
    end
    w_mult_x   = w_neg ? ~w_mult : w_mult;
    w_pp       = w_mult_x << {r_cnt, 1'b0};
    // Carry-in of the two's-complement negation lands at the digit's weight
    w_cin      = {{(PW-1){1'b0}}, w_neg} << {r_cnt, 1'b0};
    w_acc_next = r_acc + w_pp + w_cin;
  end

  // Control FSM with registered busy/done/p
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_acc   <= {PW{1'b0}};
      r_cnt   <= {CW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      p       <= {PW{1'b0}};
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= {PW{1'b0}};
            r_cnt   <= {CW{1'b0}};
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          if (r_cnt == CNT_LAST) begin
            p       <= w_acc_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
            busy    <= 1'b1;
            done    <= 1'b0;
            r_state <= RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed vector table, multi-cycle
// corner sequences and randomized back-to-back operands against an arithmetic model.
module tb_booth_mult_seq;

  localparam int W      = 16;
  localparam int N_RAND = 10000;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t tbl [10];

  logic [W-1:0] ra [N_RAND];
  logic [W-1:0] rb [N_RAND];

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    longint pr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    pr = sx * sy;
    return pr[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called right after the accepting edge; returns the cycle index where done is seen
  task automatic wait_done(input logic [2*W-1:0] p_hold, output int n, output int bc,
                           output bit stable, output bit tmo);
    n = 1; bc = 0; stable = 1'b1; tmo = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      if (p !== p_hold) stable = 1'b0;
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      tmo = 1'b1;
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done at 9", n);
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [2*W-1:0] exp);
    int n; int bc; bit st; bit tmo;
    logic [2*W-1:0] hold;
    hold  = p;
    a     = xa;
    b     = xb;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(hold, n, bc, st, tmo);
    if (!tmo) begin
      chk({name, "_lat"},  64'(n),  64'd9);
      chk({name, "_busy"}, 64'(bc), 64'd8);
      chk({name, "_hold"}, 64'(st), 64'd1);
      chk({name, "_p"},    64'(p),  64'(exp));
      chk({name, "_dbusy"}, 64'(busy), 64'd0);
      tick();
      chk({name, "_pulse"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    int n; int bc; int nd; bit st; bit tmo;
    logic [2*W-1:0] hold;
    logic [2*W-1:0] got;
    logic [2*W-1:0] exp;

    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;

    tbl[0] = '{16'd3,    16'd5,    32'h0000_000F};
    tbl[1] = '{16'hFFF9, 16'd6,    32'hFFFF_FFD6};
    tbl[2] = '{16'h8000, 16'h8000, 32'h4000_0000};
    tbl[3] = '{16'h7FFF, 16'h8000, 32'hC000_8000};
    tbl[4] = '{16'h0000, 16'h0000, 32'h0000_0000};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 32'h0000_0001};
    tbl[6] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
    tbl[7] = '{16'h8000, 16'h0001, 32'hFFFF_8000};
    tbl[8] = '{16'h8000, 16'hFFFF, 32'h0000_8000};
    tbl[9] = '{16'h0001, 16'hFFFF, 32'hFFFF_FFFF};

    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_p",    64'(p),    64'd0);

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].va, tbl[i].vb, tbl[i].exp);
    end

    // Back-to-back with start held: next operands presented during DONE
    a = 16'd2; b = 16'd3; start = 1'b1;
    tick();
    wait_done(p, n, bc, st, tmo);
    if (!tmo) begin
      chk("b2b_lat1", 64'(n), 64'd9);
      chk("b2b_p1",   64'(p), 64'h6);
      chk("b2b_dbusy", 64'(busy), 64'd0);
      a = 16'd4; b = 16'hFFFF;
      hold = p;
      tick();
      chk("b2b_nogap_busy", 64'(busy), 64'd1);
      chk("b2b_nogap_done", 64'(done), 64'd0);
      wait_done(hold, n, bc, st, tmo);
      if (!tmo) begin
        chk("b2b_lat2",  64'(n),  64'd9);
        chk("b2b_hold2", 64'(st), 64'd1);
        chk("b2b_p2",    64'(p),  64'hFFFF_FFFC);
      end
    end
    start = 1'b0;
    tick();

    // Operands and start wiggled during RUN must not disturb the result
    exp = ref_mul(16'h1234, 16'hFEDC);
    a = 16'h1234; b = 16'hFEDC; start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      start = i[0];
      tick();
    end
    start = 1'b0;
    nd = 0; got = '0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        nd++;
        got = p;
      end
      tick();
    end
    chk("midrun_ndone", 64'(nd),  64'd1);
    chk("midrun_p",     64'(got), 64'(exp));

    // Reset in the 4th RUN cycle abandons the operation
    a = 16'd100; b = 16'd200; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_p",    64'(p),    64'd0);
    nd = 0; bc = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) nd++;
      if (busy === 1'b1) bc++;
      tick();
    end
    chk("midrst_nodone", 64'(nd), 64'd0);
    chk("midrst_idle",   64'(bc), 64'd0);
    do_op("after_rst", 16'd100, 16'd200, 32'd20000);

    // Randomized back-to-back stream, corners first
    for (int i = 0; i < N_RAND; i++) begin
      case (i)
        0: begin ra[i] = 16'h0000; rb[i] = 16'h0000; end
        1: begin ra[i] = 16'hFFFF; rb[i] = 16'hFFFF; end
        2: begin ra[i] = 16'h0000; rb[i] = 16'hFFFF; end
        3: begin ra[i] = 16'hFFFF; rb[i] = 16'h0000; end
        default: begin ra[i] = 16'($urandom); rb[i] = 16'($urandom); end
      endcase
    end
    a = ra[0]; b = rb[0]; start = 1'b1;
    tick();
    hold = p;
    for (int i = 0; i < N_RAND; i++) begin
      wait_done(hold, n, bc, st, tmo);
      if (tmo) break;
      exp = ref_mul(ra[i], rb[i]);
      if (p !== exp || n != 9 || st != 1'b1) begin
        $display("FAIL rand%0d: got p=%h lat=%0d hold=%0d expected p=%h lat=9 hold=1 (a=%h b=%h)",
                 i, p, n, st, exp, ra[i], rb[i]);
        errors++;
      end
      checks++;
      hold = exp;
      if (i < N_RAND - 1) begin
        a = ra[i+1];
        b = rb[i+1];
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
